// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - redirect, instruction-memory and ID-side signals of the fetch unit
interface fetch_pc_unit_if;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc8;
   logic        if_exc;
   logic        id_ready;
   logic [31:0] fetch_cnt;

   modport master (
      input  redir_valid, redir_target, imem_ready, imem_rdata, id_ready,
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc8, if_exc, fetch_cnt
   );

   modport slave (
      output redir_valid, redir_target, imem_ready, imem_rdata, id_ready,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc8, if_exc, fetch_cnt
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC register and fetch sequencer with one-entry output buffer
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input logic              clk,
   input logic              reset_n,
   fetch_pc_unit_if.master  bus
);
   typedef enum logic [0:0] {S_FETCH, S_HALT} state_t;

   localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_pend_valid;
   logic [31:0] r_pend_target;
   logic        r_if_valid;
   logic [31:0] r_if_instr;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_pc8;
   logic        r_if_exc;
   logic [31:0] r_fetch_cnt;

   logic w_slot_free;
   logic w_bad;
   logic w_req;
   logic w_accept;
   logic w_consume;

   assign w_slot_free = !r_if_valid || bus.id_ready;
   assign w_bad       = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || ({1'b0, r_pc} >= IM_LIMIT);
   // Reset gates the request combinationally so no fetch leaks out while reset_n is low.
   assign w_req       = reset_n && (r_state == S_FETCH) && !w_bad && w_slot_free;
   assign w_accept    = w_req && bus.imem_ready;
   assign w_consume   = r_if_valid && bus.id_ready;

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = r_pc;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_instr  = r_if_instr;
   assign bus.if_pc     = r_if_pc;
   assign bus.if_pc8    = r_if_pc8;
   assign bus.if_exc    = r_if_exc;
   assign bus.fetch_cnt = r_fetch_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_pend_valid  <= 1'b0;
         r_pend_target <= 32'h0;
         r_if_valid    <= 1'b0;
         r_if_instr    <= 32'h0;
         r_if_pc       <= 32'h0;
         r_if_pc8      <= 32'h0;
         r_if_exc      <= 1'b0;
         r_fetch_cnt   <= 32'h0;
      end else begin
         if (w_consume)
            r_fetch_cnt <= r_fetch_cnt + 32'd1;

         case (r_state)
            S_FETCH: begin
               if (w_bad) begin
                  if (w_slot_free) begin
                     r_if_valid   <= 1'b1;
                     r_if_instr   <= 32'h0;
                     r_if_pc      <= r_pc;
                     r_if_pc8     <= r_pc + 32'd8;
                     r_if_exc     <= 1'b1;
                     r_pend_valid <= 1'b0;
                     r_state      <= S_HALT;
                  end
               end else if (w_accept) begin
                  // The word accepted here is the delay slot of any redirect seen now or pending.
                  r_if_valid   <= 1'b1;
                  r_if_instr   <= bus.imem_rdata;
                  r_if_pc      <= r_pc;
                  r_if_pc8     <= r_pc + 32'd8;
                  r_if_exc     <= 1'b0;
                  r_pend_valid <= 1'b0;
                  if (bus.redir_valid)
                     r_pc <= bus.redir_target;
                  else if (r_pend_valid)
                     r_pc <= r_pend_target;
                  else
                     r_pc <= r_pc + 32'd4;
               end else begin
                  if (w_consume)
                     r_if_valid <= 1'b0;
                  if (bus.redir_valid) begin
                     r_pend_valid  <= 1'b1;
                     r_pend_target <= bus.redir_target;
                  end
               end
            end
            S_HALT: begin
               if (w_consume)
                  r_if_valid <= 1'b0;
               r_pend_valid <= 1'b0;
               if (bus.redir_valid) begin
                  r_pc    <= bus.redir_target;
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed vector bench for fetch_pc_unit
module tb_fetch_pc_unit;
   logic clk;
   logic reset_n;
   fetch_pc_unit_if bus ();

   fetch_pc_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory returns an address-derived word in the same cycle.
   assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

   typedef struct {
      logic        rv;
      logic [31:0] tgt;
      logic        rdy;
      logic        idr;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_v;
      logic [31:0] exp_pc;
      logic        exp_exc;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic vec_t mk(logic rv, logic [31:0] tgt, logic rdy, logic idr,
                               logic req, logic [31:0] addr, logic v, logic [31:0] pc,
                               logic exc, logic [31:0] cnt);
      vec_t t;
      t.rv = rv; t.tgt = tgt; t.rdy = rdy; t.idr = idr;
      t.exp_req = req; t.exp_addr = addr; t.exp_v = v; t.exp_pc = pc;
      t.exp_exc = exc; t.exp_cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
      end
   endtask

   task automatic chk_entry(input int row, input logic v, input logic [31:0] pc,
                            input logic exc, input logic [31:0] cnt);
      chk("if_valid", row, 32'(bus.if_valid), 32'(v));
      chk("fetch_cnt", row, bus.fetch_cnt, cnt);
      if (v) begin
         chk("if_pc", row, bus.if_pc, pc);
         chk("if_pc8", row, bus.if_pc8, pc + 32'd8);
         chk("if_exc", row, 32'(bus.if_exc), 32'(exc));
         chk("if_instr", row, bus.if_instr, exc ? 32'h0 : (pc ^ 32'hDEAD_0000));
      end
   endtask

   initial begin
      // Streaming and delay-slot redirect
      vecs.push_back(mk(0, 0,           1, 1, 1, 32'h3000, 1, 32'h3000, 0, 0));
      vecs.push_back(mk(0, 0,           1, 1, 1, 32'h3004, 1, 32'h3004, 0, 1));
      vecs.push_back(mk(1, 32'h3100,    1, 1, 1, 32'h3008, 1, 32'h3008, 0, 2));
      vecs.push_back(mk(0, 0,           1, 1, 1, 32'h3100, 1, 32'h3100, 0, 3));
      vecs.push_back(mk(1, 32'h3010,    1, 1, 1, 32'h3104, 1, 32'h3104, 0, 4));
      // Stalled request at 3010 with redirect to 3200 in its first cycle
      vecs.push_back(mk(1, 32'h3200,    0, 1, 1, 32'h3010, 0, 32'h0,    0, 5));
      vecs.push_back(mk(0, 0,           0, 1, 1, 32'h3010, 0, 32'h0,    0, 5));
      vecs.push_back(mk(0, 0,           0, 1, 1, 32'h3010, 0, 32'h0,    0, 5));
      vecs.push_back(mk(0, 0,           1, 1, 1, 32'h3010, 1, 32'h3010, 0, 5));
      vecs.push_back(mk(0, 0,           1, 1, 1, 32'h3200, 1, 32'h3200, 0, 6));
      // ID backpressure for five cycles
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0,        1, 0, 0, 32'h3204, 1, 32'h3200, 0, 6));
      vecs.push_back(mk(0, 0,           1, 1, 1, 32'h3204, 1, 32'h3204, 0, 7));
      // Misaligned redirect -> exception entry, halt, restart at 3000
      vecs.push_back(mk(1, 32'h3002,    1, 1, 1, 32'h3208, 1, 32'h3208, 0, 8));
      vecs.push_back(mk(0, 0,           1, 1, 0, 32'h3002, 1, 32'h3002, 1, 9));
      vecs.push_back(mk(0, 0,           1, 1, 0, 32'h3002, 0, 32'h0,    0, 10));
      vecs.push_back(mk(0, 0,           1, 1, 0, 32'h3002, 0, 32'h0,    0, 10));
      vecs.push_back(mk(1, 32'h3000,    1, 1, 0, 32'h3002, 0, 32'h0,    0, 10));
      vecs.push_back(mk(0, 0,           1, 1, 1, 32'h3000, 1, 32'h3000, 0, 10));
      // Upper bound: 7000 is just past the legal range, 6FFC is the last legal word
      vecs.push_back(mk(1, 32'h7000,    1, 1, 1, 32'h3004, 1, 32'h3004, 0, 11));
      vecs.push_back(mk(0, 0,           1, 1, 0, 32'h7000, 1, 32'h7000, 1, 12));
      vecs.push_back(mk(1, 32'h6FFC,    1, 1, 0, 32'h7000, 0, 32'h0,    0, 13));
      vecs.push_back(mk(1, 32'h3100,    1, 1, 1, 32'h6FFC, 1, 32'h6FFC, 0, 13));

      reset_n          = 1'b0;
      bus.redir_valid  = 1'b0;
      bus.redir_target = 32'h0;
      bus.imem_ready   = 1'b1;
      bus.id_ready     = 1'b1;
      @(negedge clk);
      #1 chk("req_in_reset", -1, 32'(bus.imem_req), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_if_valid", -1, 32'(bus.if_valid), 32'h0);
      chk("rst_if_pc", -1, bus.if_pc, 32'h0);
      chk("rst_if_instr", -1, bus.if_instr, 32'h0);
      chk("rst_fetch_cnt", -1, bus.fetch_cnt, 32'h0);
      chk("rst_addr", -1, bus.imem_addr, 32'h3000);
      @(negedge clk);
      reset_n = 1'b1;

      for (int r = 0; r < vecs.size(); r++) begin
         if (r != 0) @(negedge clk);
         bus.redir_valid  = vecs[r].rv;
         bus.redir_target = vecs[r].tgt;
         bus.imem_ready   = vecs[r].rdy;
         bus.id_ready     = vecs[r].idr;
         #1;
         chk("imem_req", r, 32'(bus.imem_req), 32'(vecs[r].exp_req));
         chk("imem_addr", r, bus.imem_addr, vecs[r].exp_addr);
         @(posedge clk);
         #1 chk_entry(r, vecs[r].exp_v, vecs[r].exp_pc, vecs[r].exp_exc, vecs[r].exp_cnt);
      end

      // Reset while a request is outstanding and an entry is valid
      @(negedge clk);
      bus.redir_valid = 1'b0;
      bus.imem_ready  = 1'b0;
      bus.id_ready    = 1'b1;
      #1;
      chk("pre_rst_req", 100, 32'(bus.imem_req), 32'h1);
      chk("pre_rst_addr", 100, bus.imem_addr, 32'h3100);
      chk("pre_rst_valid", 100, 32'(bus.if_valid), 32'h1);
      reset_n = 1'b0;
      #1 chk("mid_rst_req", 100, 32'(bus.imem_req), 32'h0);
      @(posedge clk);
      #1;
      chk("post_rst_valid", 100, 32'(bus.if_valid), 32'h0);
      chk("post_rst_cnt", 100, bus.fetch_cnt, 32'h0);
      chk("post_rst_addr", 100, bus.imem_addr, 32'h3000);
      @(negedge clk);
      reset_n        = 1'b1;
      bus.imem_ready = 1'b1;
      #1 chk("restart_req", 101, 32'(bus.imem_req), 32'h1);
      @(posedge clk);
      #1 chk_entry(101, 1'b1, 32'h3000, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
